// File: rtl/wvb_rdout_sched_pkg.sv
// Shared encodings and widths for the waveform readout scheduler.
package wvb_rdout_sched_pkg;

  localparam int WVF_CNT_W = 10;
  localparam int LEN_W     = 16;
  localparam int TMO_W     = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ARB     = 3'd1;
  localparam state_t ST_REQ     = 3'd2;
  localparam state_t ST_POST    = 3'd3;
  localparam state_t ST_WAIT_HI = 3'd4;
  localparam state_t ST_WAIT_LO = 3'd5;
  localparam state_t ST_ERR     = 3'd6;

  // Channel index width; a single-bit index is kept even for tiny N.
  function automatic int chan_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wvb_rdout_sched_rr_arbiter.sv
// Combinational round-robin picker: priority-masked requests win, else any request,
// searching from the slot after the pointer.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int CW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_pri,
  input  logic [CW-1:0] i_ptr,
  output logic [CW-1:0] o_gnt,
  output logic          o_vld
);

  localparam int SW = CW + 1;

  logic [N-1:0]  w_hi;
  logic [N-1:0]  w_cand;
  logic [N-1:0]  w_rot;
  logic [SW-1:0] w_start;
  logic [SW-1:0] w_off;
  logic [SW-1:0] w_sum;

  assign w_hi    = i_req & i_pri;
  assign w_cand  = (|w_hi) ? w_hi : i_req;
  // Start may equal N; shifting the doubled vector by N returns it unrotated.
  assign w_start = SW'(i_ptr) + SW'(1);
  assign w_rot   = N'({w_cand, w_cand} >> w_start);

  always_comb begin
    w_off = '0;
    o_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = SW'(k);
        o_vld = 1'b1;
      end
    end
  end

  assign w_sum = w_start + w_off;
  assign o_gnt = (w_sum >= SW'(N)) ? CW'(w_sum - SW'(N)) : CW'(w_sum);

endmodule

// File: rtl/wvb_rdout_sched.sv
// Waveform readout scheduler: arbitrates buffers into the shared reader and, in
// DPRAM mode, posts each waveform to the host through the run/busy handshake.
module wvb_rdout_sched
  import wvb_rdout_sched_pkg::*;
#(
  parameter  int N_CHANNELS     = 2,
  parameter  int TIMEOUT_CYCLES = 65535,
  localparam int CHAN_W         = chan_w(N_CHANNELS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            dpram_mode,
  input  logic [WVF_CNT_W*N_CHANNELS-1:0] wvb_n_wvf_in_buf,
  input  logic [N_CHANNELS-1:0]           wvb_hdr_full,
  output logic                            rd_req,
  output logic [CHAN_W-1:0]               rd_chan,
  input  logic                            rd_ack,
  input  logic [LEN_W-1:0]                rd_len,
  output logic                            rdout_dpram_run,
  output logic [LEN_W-1:0]                dpram_len_out,
  input  logic                            dpram_busy,
  output logic                            sched_busy,
  output logic                            timeout_err,
  input  logic                            err_clr,
  output logic [LEN_W-1:0]                rdout_cnt
);

  state_t              r_state;
  state_t              w_nxt;
  logic [CHAN_W-1:0]   r_chan;
  logic [CHAN_W-1:0]   r_ptr;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_cnt;
  logic [TMO_W-1:0]    r_tmo;
  logic [N_CHANNELS-1:0] w_elig;
  logic [CHAN_W-1:0]   w_gnt;
  logic                w_gnt_vld;
  logic                w_timed;
  logic                w_tmo_hit;
  logic                w_ack;
  state_t              w_done_st;

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_elig
    assign w_elig[i] = |wvb_n_wvf_in_buf[i*WVF_CNT_W +: WVF_CNT_W];
  end

  rr_arbiter #(
    .N  (N_CHANNELS),
    .CW (CHAN_W)
  ) u_arb (
    .i_req (w_elig),
    .i_pri (wvb_hdr_full),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_vld (w_gnt_vld)
  );

  assign w_timed   = (r_state == ST_REQ) || (r_state == ST_WAIT_HI) || (r_state == ST_WAIT_LO);
  assign w_tmo_hit = w_timed && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_ack     = (r_state == ST_REQ) && rd_ack;
  assign w_done_st = enable ? ST_ARB : ST_IDLE;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt;
  end

  // Handshake events are checked before the timeout so a completion on the
  // expiring cycle still counts as a normal completion.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (enable) w_nxt = ST_ARB;
      ST_ARB:     if (!enable) w_nxt = ST_IDLE;
                  else if (w_gnt_vld) w_nxt = ST_REQ;
      ST_REQ:     if (rd_ack) w_nxt = dpram_mode ? ST_POST : w_done_st;
                  else if (w_tmo_hit) w_nxt = ST_ERR;
      ST_POST:    w_nxt = ST_WAIT_HI;
      ST_WAIT_HI: if (dpram_busy) w_nxt = ST_WAIT_LO;
                  else if (w_tmo_hit) w_nxt = ST_ERR;
      ST_WAIT_LO: if (!dpram_busy) w_nxt = w_done_st;
                  else if (w_tmo_hit) w_nxt = ST_ERR;
      ST_ERR:     if (err_clr) w_nxt = ST_IDLE;
      default:    w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_req          = 1'b0;
    rdout_dpram_run = 1'b0;
    timeout_err     = 1'b0;
    sched_busy      = 1'b1;
    case (r_state)
      ST_IDLE: sched_busy = 1'b0;
      ST_REQ:  rd_req = 1'b1;
      ST_POST: rdout_dpram_run = 1'b1;
      ST_ERR: begin
        sched_busy  = 1'b0;
        timeout_err = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chan <= '0;
      r_ptr  <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_tmo  <= '0;
    end else begin
      if ((r_state == ST_ARB) && enable && w_gnt_vld) r_chan <= w_gnt;
      if (w_ack) begin
        r_ptr <= r_chan;
        r_cnt <= r_cnt + LEN_W'(1);
        if (dpram_mode) r_len <= rd_len;
      end
      if (w_nxt != r_state) r_tmo <= '0;
      else if (w_timed)     r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  assign rd_chan       = r_chan;
  assign dpram_len_out = r_len;
  assign rdout_cnt     = r_cnt;

endmodule

// File: tb/tb_wvb_rdout_sched.sv
// Scoreboard bench for wvb_rdout_sched: a rule-level model predicts each grant and
// posted length; a monitor compares whenever the DUT raises rd_req or run.
module tb_wvb_rdout_sched;
  localparam int N   = 4;
  localparam int CW  = 2;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst, enable, dpram_mode, rd_ack, dpram_busy, err_clr;
  logic [10*N-1:0] wvb_n_wvf_in_buf;
  logic [N-1:0]    wvb_hdr_full;
  logic [15:0]     rd_len;
  logic            rd_req, rdout_dpram_run, sched_busy, timeout_err;
  logic [CW-1:0]   rd_chan;
  logic [15:0]     dpram_len_out, rdout_cnt;

  always #5 clk = ~clk;

  wvb_rdout_sched #(.N_CHANNELS(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .dpram_mode(dpram_mode),
    .wvb_n_wvf_in_buf(wvb_n_wvf_in_buf), .wvb_hdr_full(wvb_hdr_full),
    .rd_req(rd_req), .rd_chan(rd_chan), .rd_ack(rd_ack), .rd_len(rd_len),
    .rdout_dpram_run(rdout_dpram_run), .dpram_len_out(dpram_len_out),
    .dpram_busy(dpram_busy), .sched_busy(sched_busy), .timeout_err(timeout_err),
    .err_clr(err_clr), .rdout_cnt(rdout_cnt)
  );

  int          n_chk = 0, n_pass = 0;
  int          m_wvf[N];
  bit          m_hf[N];
  int          m_ptr = 0, m_done = 0, m_pend = -1;
  int          exp_chan[$];
  logic [15:0] exp_len[$];
  bit          post_pend = 0;
  bit          h_rand = 1;
  int          h_d1 = 1, h_d2 = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s: got no event expected event within bound", nm);
  endtask

  // Next grant from the rules: header-full eligible first, else any eligible,
  // each searched from the slot after the last served channel.
  function automatic int pick();
    for (int pass = 0; pass < 2; pass++)
      for (int k = 1; k <= N; k++) begin
        int c = (m_ptr + k) % N;
        if (m_wvf[c] != 0 && (pass == 1 || m_hf[c])) return c;
      end
    return -1;
  endfunction

  task automatic drive_bufs();
    for (int i = 0; i < N; i++) begin
      wvb_n_wvf_in_buf[i*10 +: 10] = 10'(m_wvf[i]);
      wvb_hdr_full[i] = m_hf[i];
    end
  endtask

  task automatic expect_next();
    drive_bufs();
    m_pend = pick();
    if (m_pend >= 0) exp_chan.push_back(m_pend);
  endtask

  task automatic randomize_bufs();
    int any = 0;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 2) == 0) m_wvf[i] += int'($urandom_range(1, 3));
      m_hf[i] = ($urandom_range(0, 3) == 0);
      any += m_wvf[i];
    end
    if (any == 0) m_wvf[$urandom_range(0, N-1)] = 1;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!rd_req && n < 100) begin @(negedge clk); n++; end
    ok = rd_req;
    if (!ok) fail("req_wait");
  endtask

  // One reader transaction: ack after dly cycles; buffers change only at the ack.
  task automatic txn(input int dly, input bit dpm, input logic [15:0] len, input bit rnd);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    repeat (dly) @(negedge clk);
    rd_ack = 1'b1; dpram_mode = dpm; rd_len = len;
    if (dpm) exp_len.push_back(len);
    if (m_pend >= 0) begin m_ptr = m_pend; m_wvf[m_pend]--; end
    m_done++;
    if (rnd) randomize_bufs();
    expect_next();
    @(negedge clk);
    rd_ack = 1'b0;
    chk("rdout_cnt", 32'(rdout_cnt), 32'(16'(m_done)));
  endtask

  // Monitor: pops the scoreboard on each new grant and each DPRAM post.
  initial begin
    bit prev_req = 0, prev_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin prev_req = 0; prev_run = 0; end
      else begin
        if (rd_req && !prev_req) begin
          if (post_pend) fail("req_during_post");
          if (exp_chan.size() == 0) fail("grant_unexpected");
          else chk("grant_chan", 32'(rd_chan), exp_chan.pop_front());
        end
        if (rdout_dpram_run) begin
          if (prev_run) fail("run_width");
          if (exp_len.size() == 0) fail("post_unexpected");
          else chk("dpram_len", 32'(dpram_len_out), 32'(exp_len.pop_front()));
        end
        prev_req = rd_req; prev_run = rdout_dpram_run;
      end
    end
  end

  // Host side of the DPRAM handshake.
  initial begin
    dpram_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rdout_dpram_run && !rst) begin
        post_pend = 1;
        repeat (h_rand ? int'($urandom_range(1, 4)) : h_d1) @(negedge clk);
        dpram_busy = 1'b1;
        repeat (h_rand ? int'($urandom_range(1, 4)) : h_d2) @(negedge clk);
        dpram_busy = 1'b0;
        post_pend = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, rose, early, fell;
    rst = 1'b1; enable = 1'b0; dpram_mode = 1'b0; rd_ack = 1'b0; err_clr = 1'b0;
    rd_len = '0; wvb_n_wvf_in_buf = '0; wvb_hdr_full = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(rd_req), 0);
    chk("rst_chan", 32'(rd_chan), 0);
    chk("rst_run", 32'(rdout_dpram_run), 0);
    chk("rst_len", 32'(dpram_len_out), 0);
    chk("rst_busy", 32'(sched_busy), 0);
    chk("rst_err", 32'(timeout_err), 0);
    chk("rst_cnt", 32'(rdout_cnt), 0);
    rst = 1'b0;

    // Stray ack while idle
    rd_ack = 1'b1; @(negedge clk); rd_ack = 1'b0; @(negedge clk);
    chk("stray_ack_cnt", 32'(rdout_cnt), 0);
    chk("stray_ack_idle", 32'(sched_busy), 0);

    // Round-robin, two channels of 3
    m_wvf[0] = 3; m_wvf[1] = 3; expect_next();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      txn(5, 1'b0, 16'h0, 1'b0);
      if (i < 5) begin @(negedge clk); chk("rr_grant_lat", 32'(rd_req), 1); end
    end
    repeat (3) @(negedge clk);
    chk("rr_total", 32'(rdout_cnt), 6);
    chk("rr_wait_arb", 32'(sched_busy), 1);
    chk("rr_no_req", 32'(rd_req), 0);

    // Header-full channel beats round-robin order
    m_wvf[0] = 2; m_wvf[1] = 2; m_hf[0] = 1; expect_next();
    for (int i = 0; i < 4; i++) txn(2, 1'b0, 16'h0, 1'b0);
    m_hf[0] = 0; drive_bufs();

    // DPRAM post with fixed host timing
    h_rand = 0; h_d1 = 5; h_d2 = 3;
    m_wvf[1] = 2; expect_next();
    txn(3, 1'b1, 16'h0123, 1'b0);
    chk("dp_run", 32'(rdout_dpram_run), 1);
    chk("dp_len", 32'(dpram_len_out), 32'h0123);
    rose = 0; early = 0; fell = 0;
    for (int i = 0; i < 40 && !fell; i++) begin
      @(posedge clk); #1;
      if (rd_req) early = 1;
      if (dpram_busy) rose = 1; else if (rose) fell = 1;
    end
    chk("dp_busy_rose", 32'(fell), 1);
    chk("dp_no_early_req", 32'(early), 0);
    @(posedge clk); #1;
    chk("dp_grant_lat", 32'(rd_req), 1);
    txn(2, 1'b0, 16'h0, 1'b0);
    h_rand = 1;

    // Reader never acks
    m_wvf[0] = 1; expect_next();
    wait_req(ok);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_req_held", 32'(rd_req), 1);
    @(negedge clk);
    chk("tmo_req_drop", 32'(rd_req), 0);
    chk("tmo_err", 32'(timeout_err), 1);
    chk("tmo_busy", 32'(sched_busy), 0);
    chk("tmo_cnt", 32'(rdout_cnt), 32'(16'(m_done)));
    expect_next();
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("errclr_flag", 32'(timeout_err), 0);
    chk("errclr_idle", 32'(sched_busy), 0);
    @(negedge clk);
    chk("errclr_arb", 32'(sched_busy), 1);
    txn(3, 1'b0, 16'h0, 1'b0);

    // Disable while the reader is busy
    m_wvf[0] = 1; m_wvf[1] = 1; expect_next();
    wait_req(ok);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("dis_req_held", 32'(rd_req), 1);
    txn(1, 1'b0, 16'h0, 1'b0);
    chk("dis_idle", 32'(sched_busy), 0);
    chk("dis_req_low", 32'(rd_req), 0);
    repeat (10) @(negedge clk);
    chk("dis_no_req", 32'(rd_req), 0);
    enable = 1'b1;
    txn(2, 1'b0, 16'h0, 1'b0);

    // Random traffic, mixed modes
    randomize_bufs(); expect_next();
    for (int i = 0; i < 60; i++)
      txn(int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), 16'($urandom), 1'b1);

    // Reset while posting
    txn(2, 1'b1, 16'h0BEE, 1'b0);
    chk("pre_rst_run", 32'(rdout_dpram_run), 1);
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    chk("rst_post_run", 32'(rdout_dpram_run), 0);
    chk("rst_post_cnt", 32'(rdout_cnt), 0);
    chk("rst_post_chan", 32'(rd_chan), 0);
    chk("rst_post_busy", 32'(sched_busy), 0);
    rst = 1'b0;
    exp_chan.delete(); exp_len.delete();
    repeat (12) @(negedge clk);
    chk("rst_stays_idle", 32'(sched_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
